// File: rtl/aes50_clk_pattern_gen.sv
// AES50 clock half-bit pattern generator: two half-bits per refclk cycle, with
// programmable period/duty and a lengthened-high marker period once per frame.
module aes50_clk_pattern_gen #(
    parameter int unsigned PERIOD_HB = 8,
    parameter int unsigned HIGH_HB   = 4,
    parameter int unsigned MARK_HB   = 6,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             refclk,
    input  logic             reset,
    input  logic             enable,
    input  logic             fs_sync,
    output logic [1:0]       data,
    output logic             running,
    output logic             period_start,
    output logic             marker_sent,
    output logic             sync_overrun,
    output logic [CNT_W-1:0] frame_periods
);

    localparam int unsigned HB_W = $clog2(PERIOD_HB + 1);
    localparam logic [HB_W-1:0] LAST_HB = HB_W'(PERIOD_HB - 2);
    localparam logic [HB_W-1:0] HIGH_L  = HB_W'(HIGH_HB);
    localparam logic [HB_W-1:0] MARK_L  = HB_W'(MARK_HB);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    logic [HB_W-1:0]   hb_cnt;
    logic [HB_W-1:0]   hl;
    logic              pending;
    logic [CNT_W-1:0]  per_cnt;

    logic              start;
    logic              mark;
    logic [HB_W-1:0]   hl_cur;
    logic [HB_W-1:0]   hb_odd;

    // The high length for the start cycle is chosen combinationally so that a
    // strobe arriving on the start cycle itself turns that period into a marker.
    always_comb begin
        start  = (state == RUN) && (hb_cnt == '0);
        mark   = start && (pending || fs_sync);
        hl_cur = hl;
        if (start) begin
            hl_cur = mark ? MARK_L : HIGH_L;
        end
        hb_odd = hb_cnt + HB_W'(1);
    end

    always_ff @(posedge refclk) begin
        if (reset) begin
            state         <= IDLE;
            hb_cnt        <= '0;
            hl            <= '0;
            pending       <= 1'b0;
            per_cnt       <= '0;
            data          <= '0;
            running       <= 1'b0;
            period_start  <= 1'b0;
            marker_sent   <= 1'b0;
            sync_overrun  <= 1'b0;
            frame_periods <= '0;
        end else begin
            running      <= (state == RUN);
            period_start <= start;
            marker_sent  <= mark;
            sync_overrun <= fs_sync && pending && !start;
            data         <= (state == RUN) ? {hb_odd < hl_cur, hb_cnt < hl_cur} : 2'b00;

            if (start) begin
                hl <= hl_cur;
            end

            if (start) begin
                pending <= 1'b0;
            end else if (fs_sync) begin
                pending <= 1'b1;
            end

            if (start) begin
                if (mark) begin
                    frame_periods <= per_cnt;
                    per_cnt       <= CNT_W'(1);
                end else if (per_cnt != '1) begin
                    per_cnt <= per_cnt + CNT_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    hb_cnt <= '0;
                    if (enable) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (hb_cnt == LAST_HB) begin
                        hb_cnt <= '0;
                        if (!enable) begin
                            state <= IDLE;
                        end
                    end else begin
                        hb_cnt <= hb_cnt + HB_W'(2);
                    end
                end
                default: begin
                    state  <= IDLE;
                    hb_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes50_clk_pattern_gen.sv
// Bench for aes50_clk_pattern_gen: table of per-cycle vectors through a scoreboard
// queue, then hand-written frame-length sequences on a default and a narrow-counter DUT.
module tb_aes50_clk_pattern_gen;

    logic        refclk = 1'b0;
    logic        reset, enable, fs_sync;
    logic [1:0]  data, data_s;
    logic        running, period_start, marker_sent, sync_overrun;
    logic        running_s, period_start_s, marker_sent_s, sync_overrun_s;
    logic [15:0] frame_periods;
    logic [3:0]  frame_periods_s;

    int checks = 0;
    int errors = 0;

    always #5 refclk = ~refclk;

    aes50_clk_pattern_gen dut (
        .refclk(refclk), .reset(reset), .enable(enable), .fs_sync(fs_sync),
        .data(data), .running(running), .period_start(period_start),
        .marker_sent(marker_sent), .sync_overrun(sync_overrun),
        .frame_periods(frame_periods)
    );

    aes50_clk_pattern_gen #(.CNT_W(4)) dut_s (
        .refclk(refclk), .reset(reset), .enable(enable), .fs_sync(fs_sync),
        .data(data_s), .running(running_s), .period_start(period_start_s),
        .marker_sent(marker_sent_s), .sync_overrun(sync_overrun_s),
        .frame_periods(frame_periods_s)
    );

    typedef struct {
        logic       rst, en, fs;
        logic [1:0] d;
        logic       ps, ms, ov, run;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    function automatic vec_t v(input logic rst, en, fs, input logic [1:0] d,
                               input logic ps, ms, ov, run);
        vec_t r;
        r.rst = rst; r.en = en; r.fs = fs; r.d = d;
        r.ps = ps; r.ms = ms; r.ov = ov; r.run = run;
        return r;
    endfunction

    task automatic check(input string name, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step(input logic rst, en, fs);
        reset = rst; enable = en; fs_sync = fs;
        @(posedge refclk);
        #1;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; fs_sync = 1'b0;

        // inputs for a cycle, outputs seen after the following edge
        tbl.push_back(v(1,0,0,2'b00,0,0,0,0)); // 0 reset
        tbl.push_back(v(0,1,0,2'b00,0,0,0,0)); // 1 enable from idle
        tbl.push_back(v(0,1,0,2'b11,1,0,0,1));
        tbl.push_back(v(0,1,0,2'b11,0,0,0,1));
        tbl.push_back(v(0,1,0,2'b00,0,0,0,1));
        tbl.push_back(v(0,1,0,2'b00,0,0,0,1));
        tbl.push_back(v(0,1,0,2'b11,1,0,0,1)); // 6
        tbl.push_back(v(0,1,1,2'b11,0,0,0,1)); // 7 fs mid-period
        tbl.push_back(v(0,1,0,2'b00,0,0,0,1));
        tbl.push_back(v(0,1,0,2'b00,0,0,0,1));
        tbl.push_back(v(0,1,0,2'b11,1,1,0,1)); // 10 marker
        tbl.push_back(v(0,1,0,2'b11,0,0,0,1));
        tbl.push_back(v(0,1,0,2'b11,0,0,0,1));
        tbl.push_back(v(0,1,0,2'b00,0,0,0,1));
        tbl.push_back(v(0,1,0,2'b11,1,0,0,1)); // 14 normal again
        tbl.push_back(v(0,1,0,2'b11,0,0,0,1));
        tbl.push_back(v(0,1,0,2'b00,0,0,0,1));
        tbl.push_back(v(0,1,0,2'b00,0,0,0,1));
        tbl.push_back(v(0,1,1,2'b11,1,1,0,1)); // 18 fs on start cycle
        tbl.push_back(v(0,1,0,2'b11,0,0,0,1));
        tbl.push_back(v(0,1,0,2'b11,0,0,0,1));
        tbl.push_back(v(0,1,0,2'b00,0,0,0,1));
        tbl.push_back(v(0,1,0,2'b11,1,0,0,1)); // 22 no extra marker
        tbl.push_back(v(0,1,1,2'b11,0,0,0,1)); // 23 fs
        tbl.push_back(v(0,1,1,2'b00,0,0,1,1)); // 24 fs again -> overrun
        tbl.push_back(v(0,1,0,2'b00,0,0,0,1));
        tbl.push_back(v(0,1,0,2'b11,1,1,0,1)); // 26 single marker
        tbl.push_back(v(0,1,0,2'b11,0,0,0,1));
        tbl.push_back(v(0,1,0,2'b11,0,0,0,1));
        tbl.push_back(v(0,1,0,2'b00,0,0,0,1));
        tbl.push_back(v(0,1,0,2'b11,1,0,0,1)); // 30
        tbl.push_back(v(0,0,0,2'b11,0,0,0,1)); // 31 enable dropped at hb 2
        tbl.push_back(v(0,0,0,2'b00,0,0,0,1));
        tbl.push_back(v(0,0,0,2'b00,0,0,0,1));
        tbl.push_back(v(0,0,0,2'b00,0,0,0,0)); // 34 idle
        tbl.push_back(v(0,0,1,2'b00,0,0,0,0)); // 35 fs in idle
        tbl.push_back(v(0,1,0,2'b00,0,0,0,0));
        tbl.push_back(v(0,1,0,2'b11,1,1,0,1)); // 37 marker on first period
        tbl.push_back(v(0,1,0,2'b11,0,0,0,1));
        tbl.push_back(v(0,1,0,2'b11,0,0,0,1));
        tbl.push_back(v(0,1,0,2'b00,0,0,0,1));
        tbl.push_back(v(0,1,0,2'b11,1,0,0,1)); // 41
        tbl.push_back(v(0,1,1,2'b11,0,0,0,1)); // 42 arm marker
        tbl.push_back(v(1,1,0,2'b00,0,0,0,0)); // 43 reset mid-run
        tbl.push_back(v(0,1,0,2'b00,0,0,0,0));
        tbl.push_back(v(0,1,0,2'b11,1,0,0,1)); // 45 pending discarded
        tbl.push_back(v(0,1,0,2'b11,0,0,0,1));
        tbl.push_back(v(0,1,0,2'b00,0,0,0,1));
        tbl.push_back(v(0,1,0,2'b00,0,0,0,1));
        tbl.push_back(v(0,0,0,2'b11,1,0,0,1)); // 49 drop enable
        tbl.push_back(v(0,0,0,2'b11,0,0,0,1));
        tbl.push_back(v(0,1,0,2'b00,0,0,0,1)); // 51 re-enable before boundary
        tbl.push_back(v(0,1,0,2'b00,0,0,0,1));
        tbl.push_back(v(0,1,0,2'b11,1,0,0,1)); // 53 seamless

        foreach (tbl[i]) begin
            vec_t e;
            exp_q.push_back(tbl[i]);
            step(tbl[i].rst, tbl[i].en, tbl[i].fs);
            e = exp_q.pop_front();
            check($sformatf("data[%0d]", i), data, e.d);
            check($sformatf("period_start[%0d]", i), period_start, e.ps);
            check($sformatf("marker_sent[%0d]", i), marker_sent, e.ms);
            check($sformatf("sync_overrun[%0d]", i), sync_overrun, e.ov);
            check($sformatf("running[%0d]", i), running, e.run);
            if (i == 0) check("frame_periods_reset", frame_periods, 0);
        end

        // frame length: markers at periods 4, 14 and 34 after RUN starts
        step(1, 0, 0);
        check("reset_frame_periods", frame_periods, 0);
        check("reset_frame_periods_s", frame_periods_s, 0);
        check("reset_data", data, 0);
        step(0, 1, 0);
        for (int i = 0; i <= 132; i++) begin
            step(0, 1, (i == 12 || i == 52 || i == 132));
            if (i == 12) begin
                check("marker_first", marker_sent, 1);
                check("frame_first", frame_periods, 3);
                check("frame_first_s", frame_periods_s, 3);
            end else if (i == 52) begin
                check("marker_10", marker_sent, 1);
                check("frame_10", frame_periods, 10);
                check("frame_10_s", frame_periods_s, 10);
            end else if (i == 132) begin
                check("marker_20", marker_sent, 1);
                check("frame_20", frame_periods, 20);
                check("frame_20_sat", frame_periods_s, 15);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
